axi4_write_arbiter_msts_2_slv: RTL
==================================

AXI4_WRITE_ARBITER_MSTS_2_SLV -- requirements
Module: axi4_write_arbiter_msts_2_slv

Interface
REQ-001 The block SHALL have parameter AXI_ID_WIDTH_P, default -1, meaning AXI ID width.
REQ-002 The block SHALL have parameter AXI_ADDR_WIDTH_P, default -1, meaning address width.
REQ-003 The block SHALL have parameter AXI_DATA_WIDTH_P, default -1, meaning data width.
REQ-004 The block SHALL have parameter AXI_STRB_WIDTH_P, default -1, meaning strobe width.
REQ-005 The block SHALL have parameter NR_OF_MASTERS_P, default -1, meaning number of masters N (2..16).
REQ-006 The block SHALL have port clk, input, 1 bit, the clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have ports mst_awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awregion[3:0], input, packed [N-1:0] of the field width, per-master AW payload.
REQ-009 The block SHALL have ports mst_awvalid (input) and mst_awready (output), each [N-1:0], per-master AW handshake.
REQ-010 The block SHALL have ports mst_wdata/wstrb/wlast, input, packed [N-1:0] of the field width, per-master W payload.
REQ-011 The block SHALL have ports mst_wvalid (input) and mst_wready (output), each [N-1:0], per-master W handshake.
REQ-012 The block SHALL have ports mst_bid and mst_bresp[1:0], output, field width, B payload broadcast to all masters.
REQ-013 The block SHALL have ports mst_bvalid (output) and mst_bready (input), each [N-1:0], per-master B handshake.
REQ-014 The block SHALL have ports slv_aw* (output, single field width) with slv_awvalid out / slv_awready in, 1 bit each, the slave AW channel.
REQ-015 The block SHALL have ports slv_wdata/wstrb/wlast (output) with slv_wvalid out / slv_wready in, the slave W channel.
REQ-016 The block SHALL have ports slv_bid, slv_bresp and slv_bvalid (input) with slv_bready (output), the slave B channel.

Function
REQ-017 The block SHALL implement FSM states IDLE_E, TRANSFER_E and WAIT_BVALID_E, allowing one outstanding write transaction at a time.
REQ-018 In IDLE_E, when any mst_awvalid is set, the block SHALL register grant as the first requesting index at or after rr_ptr, searching upward with wrap from N-1 to 0, and SHALL enter TRANSFER_E on the next cycle.
REQ-019 In IDLE_E, all mst_awready, mst_wready, mst_bvalid, slv_awvalid, slv_wvalid and slv_bready SHALL be 0.
REQ-020 In TRANSFER_E, the block SHALL drive the slave AW payload from master grant, set slv_awvalid = mst_awvalid[grant] & !aw_done, and set mst_awready[grant] = slv_awready & !aw_done.
REQ-021 In TRANSFER_E, the block SHALL route the W channel from master grant in the same way, gated by !w_done; W beats SHALL be accepted before, during or after the AW handshake.
REQ-022 The block SHALL set aw_done on the AW handshake and w_done on a W handshake with wlast=1.
REQ-023 The block SHALL leave TRANSFER_E for WAIT_BVALID_E when both flags are set, including when both are set in the same cycle.
REQ-024 In WAIT_BVALID_E, the block SHALL set mst_bvalid[grant] = slv_bvalid, slv_bready = mst_bready[grant], and mst_bid/mst_bresp = slv_bid/slv_bresp.
REQ-025 On the B handshake, the block SHALL return to IDLE_E, set rr_ptr = grant+1 (wrapping N-1 to 0), and clear both flags.
REQ-026 Non-granted masters SHALL see 0 on all ready and valid outputs; mst_bid/mst_bresp SHALL be 0 outside WAIT_BVALID_E.
REQ-027 The slave AW/W payload outputs SHALL be 0 in IDLE_E.
REQ-028 Arbitration latency SHALL be 1 cycle: slv_awvalid is asserted no earlier than the cycle after mst_awvalid is first seen in IDLE_E.
REQ-029 The block SHALL hold grant constant from IDLE_E exit until the B handshake; new requests SHALL NOT preempt it.
REQ-030 A master that deasserts awvalid after grant SHALL keep the grant; the block SHALL wait in TRANSFER_E indefinitely.

Reset
REQ-031 On rst_n=0, asynchronously: state = IDLE_E, grant = 0, rr_ptr = 0, aw_done = w_done = 0, and all outputs 0.
REQ-032 Reset mid-transaction SHALL abort the transaction with no further handshakes; arbitration SHALL restart from rr_ptr = 0.

Verification
REQ-033 N=4, only master 2 writes awlen=3 -> slv_awvalid 1 cycle after request, 4 W beats forwarded, B delivered only to mst_bvalid[2], rr_ptr=3.
REQ-034 All 4 masters request continuously from reset -> grants in order 0,1,2,3,0, one complete transaction each.
REQ-035 Master 1 presents W with wlast before AW, slave delays awready 5 cycles -> exactly one AW and one W handshake each, then WAIT_BVALID_E.
REQ-036 AW and final W handshake in the same cycle -> WAIT_BVALID_E next cycle, with no duplicate slave valid.
REQ-037 Master 3 granted, rr_ptr=0, masters 0 and 3 request after B -> next grant is 0; with rr_ptr=3 and masters 0 and 3 requesting -> grant is 3.
REQ-038 rst_n pulsed low during W beat 2 of 4 -> all outputs 0 immediately, IDLE_E, next grant uses rr_ptr=0.

Source files
------------

// File: rtl/axi4_write_arbiter_msts_2_slv_if.sv
// Bundle for the N-master to 1-slave AXI4 write arbiter.
// The "slave" modport is the arbiter's view: it is the slave of the
// upstream masters and drives the downstream slave AW/W/B channels.
// The "master" modport is the environment's view of the same wires.
interface axi4_write_arbiter_msts_2_slv_if #(
   parameter int AXI_ID_WIDTH_P   = -1,
   parameter int AXI_ADDR_WIDTH_P = -1,
   parameter int AXI_DATA_WIDTH_P = -1,
   parameter int AXI_STRB_WIDTH_P = -1,
   parameter int NR_OF_MASTERS_P  = -1
);
   // Per-master AW channel
   logic [NR_OF_MASTERS_P-1:0][AXI_ID_WIDTH_P-1:0]   mst_awid;
   logic [NR_OF_MASTERS_P-1:0][AXI_ADDR_WIDTH_P-1:0] mst_awaddr;
   logic [NR_OF_MASTERS_P-1:0][7:0]                  mst_awlen;
   logic [NR_OF_MASTERS_P-1:0][2:0]                  mst_awsize;
   logic [NR_OF_MASTERS_P-1:0][1:0]                  mst_awburst;
   logic [NR_OF_MASTERS_P-1:0][3:0]                  mst_awregion;
   logic [NR_OF_MASTERS_P-1:0]                       mst_awvalid;
   logic [NR_OF_MASTERS_P-1:0]                       mst_awready;
   // Per-master W channel
   logic [NR_OF_MASTERS_P-1:0][AXI_DATA_WIDTH_P-1:0] mst_wdata;
   logic [NR_OF_MASTERS_P-1:0][AXI_STRB_WIDTH_P-1:0] mst_wstrb;
   logic [NR_OF_MASTERS_P-1:0]                       mst_wlast;
   logic [NR_OF_MASTERS_P-1:0]                       mst_wvalid;
   logic [NR_OF_MASTERS_P-1:0]                       mst_wready;
   // B channel, payload broadcast
   logic [AXI_ID_WIDTH_P-1:0]                        mst_bid;
   logic [1:0]                                       mst_bresp;
   logic [NR_OF_MASTERS_P-1:0]                       mst_bvalid;
   logic [NR_OF_MASTERS_P-1:0]                       mst_bready;
   // Slave AW channel
   logic [AXI_ID_WIDTH_P-1:0]                        slv_awid;
   logic [AXI_ADDR_WIDTH_P-1:0]                      slv_awaddr;
   logic [7:0]                                       slv_awlen;
   logic [2:0]                                       slv_awsize;
   logic [1:0]                                       slv_awburst;
   logic [3:0]                                       slv_awregion;
   logic                                             slv_awvalid;
   logic                                             slv_awready;
   // Slave W channel
   logic [AXI_DATA_WIDTH_P-1:0]                      slv_wdata;
   logic [AXI_STRB_WIDTH_P-1:0]                      slv_wstrb;
   logic                                             slv_wlast;
   logic                                             slv_wvalid;
   logic                                             slv_wready;
   // Slave B channel
   logic [AXI_ID_WIDTH_P-1:0]                        slv_bid;
   logic [1:0]                                       slv_bresp;
   logic                                             slv_bvalid;
   logic                                             slv_bready;

   modport slave (
      input  mst_awid, mst_awaddr, mst_awlen, mst_awsize, mst_awburst, mst_awregion, mst_awvalid,
      output mst_awready,
      input  mst_wdata, mst_wstrb, mst_wlast, mst_wvalid,
      output mst_wready,
      output mst_bid, mst_bresp, mst_bvalid,
      input  mst_bready,
      output slv_awid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awregion, slv_awvalid,
      input  slv_awready,
      output slv_wdata, slv_wstrb, slv_wlast, slv_wvalid,
      input  slv_wready,
      input  slv_bid, slv_bresp, slv_bvalid,
      output slv_bready
   );

   modport master (
      output mst_awid, mst_awaddr, mst_awlen, mst_awsize, mst_awburst, mst_awregion, mst_awvalid,
      input  mst_awready,
      output mst_wdata, mst_wstrb, mst_wlast, mst_wvalid,
      input  mst_wready,
      input  mst_bid, mst_bresp, mst_bvalid,
      output mst_bready,
      input  slv_awid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awregion, slv_awvalid,
      output slv_awready,
      input  slv_wdata, slv_wstrb, slv_wlast, slv_wvalid,
      output slv_wready,
      output slv_bid, slv_bresp, slv_bvalid,
      input  slv_bready
   );
endinterface

// File: rtl/axi4_write_arbiter_msts_2_slv.sv
// Round-robin write arbiter: N AXI4 masters share one slave, one write
// transaction outstanding at a time.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// IDLE_E         | no transaction; pick next requester from rr_ptr
// TRANSFER_E     | AW and W of granted master routed until both finish
// WAIT_BVALID_E  | B response routed back to granted master only
module axi4_write_arbiter_msts_2_slv #(
   parameter int AXI_ID_WIDTH_P   = -1,
   parameter int AXI_ADDR_WIDTH_P = -1,
   parameter int AXI_DATA_WIDTH_P = -1,
   parameter int AXI_STRB_WIDTH_P = -1,
   parameter int NR_OF_MASTERS_P  = -1
) (
   input logic                         clk,
   input logic                         rst_n,
   axi4_write_arbiter_msts_2_slv_if.slave bus
);

   localparam int IDX_W_P = (NR_OF_MASTERS_P > 1) ? $clog2(NR_OF_MASTERS_P) : 1;

   typedef enum logic [1:0] {
      IDLE_E        = 2'd0,
      TRANSFER_E    = 2'd1,
      WAIT_BVALID_E = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W_P-1:0]   grant_q, grant_d;
   logic [IDX_W_P-1:0]   rr_ptr_q, rr_ptr_d;
   logic                 aw_done_q, aw_done_d;
   logic                 w_done_q, w_done_d;

   logic [IDX_W_P-1:0]   pick;
   logic                 pick_found;
   logic                 aw_hs;
   logic                 w_last_hs;
   logic                 b_hs;

   // (base + ofs) modulo N, with ofs < N so one subtraction suffices
   function automatic logic [IDX_W_P-1:0] wrap_idx(input logic [IDX_W_P-1:0] base,
                                                  input int unsigned        ofs);
      int unsigned sum;
      sum = 32'(base) + ofs;
      if (sum >= 32'(NR_OF_MASTERS_P)) sum = sum - 32'(NR_OF_MASTERS_P);
      return IDX_W_P'(sum);
   endfunction

   // First requesting master at or after rr_ptr, searching upward with wrap
   always_comb begin
      pick       = rr_ptr_q;
      pick_found = 1'b0;
      for (int i = 0; i < NR_OF_MASTERS_P; i++) begin
         if (!pick_found && bus.mst_awvalid[wrap_idx(rr_ptr_q, 32'(i))]) begin
            pick       = wrap_idx(rr_ptr_q, 32'(i));
            pick_found = 1'b1;
         end
      end
   end

   // State, grant, pointer and completion flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE_E;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Next-state and channel routing; everything not owned by the grant is 0
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      aw_hs     = 1'b0;
      w_last_hs = 1'b0;
      b_hs      = 1'b0;

      bus.mst_awready  = '0;
      bus.mst_wready   = '0;
      bus.mst_bvalid   = '0;
      bus.mst_bid      = '0;
      bus.mst_bresp    = '0;
      bus.slv_awid     = '0;
      bus.slv_awaddr   = '0;
      bus.slv_awlen    = '0;
      bus.slv_awsize   = '0;
      bus.slv_awburst  = '0;
      bus.slv_awregion = '0;
      bus.slv_awvalid  = 1'b0;
      bus.slv_wdata    = '0;
      bus.slv_wstrb    = '0;
      bus.slv_wlast    = 1'b0;
      bus.slv_wvalid   = 1'b0;
      bus.slv_bready   = 1'b0;

      case (state_q)
         IDLE_E: begin
            if (pick_found) begin
               grant_d   = pick;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = TRANSFER_E;
            end
         end

         TRANSFER_E: begin
            bus.slv_awid     = bus.mst_awid[grant_q];
            bus.slv_awaddr   = bus.mst_awaddr[grant_q];
            bus.slv_awlen    = bus.mst_awlen[grant_q];
            bus.slv_awsize   = bus.mst_awsize[grant_q];
            bus.slv_awburst  = bus.mst_awburst[grant_q];
            bus.slv_awregion = bus.mst_awregion[grant_q];
            bus.slv_awvalid  = bus.mst_awvalid[grant_q] & ~aw_done_q;
            bus.mst_awready[grant_q] = bus.slv_awready & ~aw_done_q;

            bus.slv_wdata    = bus.mst_wdata[grant_q];
            bus.slv_wstrb    = bus.mst_wstrb[grant_q];
            bus.slv_wlast    = bus.mst_wlast[grant_q];
            bus.slv_wvalid   = bus.mst_wvalid[grant_q] & ~w_done_q;
            bus.mst_wready[grant_q] = bus.slv_wready & ~w_done_q;

            aw_hs     = bus.mst_awvalid[grant_q] & bus.slv_awready & ~aw_done_q;
            w_last_hs = bus.mst_wvalid[grant_q] & bus.slv_wready & ~w_done_q
                        & bus.mst_wlast[grant_q];
            if (aw_hs)     aw_done_d = 1'b1;
            if (w_last_hs) w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = WAIT_BVALID_E;
         end

         WAIT_BVALID_E: begin
            bus.mst_bvalid[grant_q] = bus.slv_bvalid;
            bus.slv_bready          = bus.mst_bready[grant_q];
            bus.mst_bid             = bus.slv_bid;
            bus.mst_bresp           = bus.slv_bresp;
            b_hs = bus.slv_bvalid & bus.mst_bready[grant_q];
            if (b_hs) begin
               state_d   = IDLE_E;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rr_ptr_d  = (grant_q == IDX_W_P'(NR_OF_MASTERS_P - 1)) ? '0
                           : grant_q + IDX_W_P'(1);
            end
         end

         default: state_d = IDLE_E;
      endcase
   end

endmodule
